// File: rtl/sum_bcd_display.sv
// Sequential 5-bit binary to two-digit BCD converter (shift-add-3) with
// active-low seven-segment decode of the registered tens/ones digits.
module sum_bcd_display #(
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [12:0] sr;
  logic [12:0] sr_adj;
  logic [12:0] sr_next;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: correct each BCD nibble, then shift.
  always_comb begin
    sr_adj  = {add3(sr[12:9]), add3(sr[8:5]), sr[4:0]};
    sr_next = {sr_adj[11:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sr <= {8'b0, bin};
    end else if (state == SHIFT) begin
      sr <= sr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      tens  <= 4'd0;
      ones  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= 3'd0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt + 3'd1;
          // Fifth shift: result is final, publish it on this same edge.
          if (cnt == 3'd4) begin
            tens  <= sr_next[12:9];
            ones  <= sr_next[8:5];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    hex0 = seg7(ones);
    hex1 = (BLANK_LEADING_ZERO && tens == 4'd0) ? 7'b1111111 : seg7(tens);
  end

endmodule

// File: tb/tb_sum_bcd_display.sv
// Bench for sum_bcd_display: directed scenarios plus random sums checked
// against a division/modulo digit model and a segment lookup table.
module tb_sum_bcd_display;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [4:0] bin;
  logic       busy, done, busy_nb, done_nb;
  logic [3:0] tens, ones, tens_nb, ones_nb;
  logic [6:0] hex1, hex0, hex1_nb, hex0_nb;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;

  sum_bcd_display #(.BLANK_LEADING_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy), .done(done),
    .tens(tens), .ones(ones), .hex1(hex1), .hex0(hex0));

  sum_bcd_display #(.BLANK_LEADING_ZERO(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy_nb), .done(done_nb),
    .tens(tens_nb), .ones(ones_nb), .hex1(hex1_nb), .hex0(hex0_nb));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected display state for a completed conversion of sum v.
  task automatic chk_result(input string tag, input int v);
    int t, o;
    t = v / 10;
    o = v % 10;
    chk({tag, "_tens"}, 32'(tens), 32'(t));
    chk({tag, "_ones"}, 32'(ones), 32'(o));
    chk({tag, "_hex0"}, 32'(hex0), 32'(seg_tab[o]));
    chk({tag, "_hex1"}, 32'(hex1), 32'((t == 0) ? BLANK : seg_tab[t]));
    chk({tag, "_hex1_nb"}, 32'(hex1_nb), 32'(seg_tab[t]));
  endtask

  // Pulse start for one cycle, wait (bounded) for done, check timing and result.
  task automatic conv(input string tag, input logic [4:0] b);
    int lat, busy_cycles;
    bin = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_cycles = int'(busy);
    while (!done && lat < 20) begin
      tick();
      lat++;
      busy_cycles += int'(busy);
    end
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    tick();
    busy_cycles += int'(busy);
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd6);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk_result(tag, int'(b));
  endtask

  initial begin
    int n_done, rise_idx, done_idx, idx;
    logic prev_busy;
    rst = 1'b1;
    start = 1'b0;
    bin = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_result("rst", 0);

    conv("b5", 5'd5);
    conv("b21", 5'd21);
    conv("b30", 5'd30);
    conv("b0", 5'd0);

    // start pulses during SHIFT and during DONE are ignored
    bin = 5'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    for (int i = 1; i <= 8; i++) begin
      start = (i == 3 || i == 6);
      if (i == 3) bin = 5'd17;
      tick();
      n_done += int'(done);
    end
    start = 1'b0;
    chk("ign_done_count", 32'(n_done), 32'd1);
    chk("ign_busy_after", 32'(busy), 32'd0);
    chk_result("ign", 9);

    // start held high: captures every 7 clocks, each with current bin
    bin = 5'd13;
    start = 1'b1;
    tick();
    bin = 5'd27;
    rise_idx = -1;
    done_idx = -1;
    prev_busy = busy;
    idx = 0;
    while (idx < 30 && (rise_idx < 0 || done_idx < 0)) begin
      tick();
      idx++;
      if (done && done_idx < 0) begin
        done_idx = idx;
        chk_result("held_first", 13);
      end
      if (busy && !prev_busy && rise_idx < 0) begin
        rise_idx = idx;
        start = 1'b0;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    chk("held_first_done", 32'(done_idx), 32'd5);
    chk("held_recapture", 32'(rise_idx), 32'd7);
    idx = 0;
    while (!done && idx < 20) begin
      tick();
      idx++;
    end
    chk("held_second_done", 32'(idx), 32'd5);
    chk_result("held_second", 27);
    tick();

    // bin changes after capture have no effect
    bin = 5'd19;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bin = 5'd2;
    idx = 0;
    while (!done && idx < 20) begin
      tick();
      idx++;
    end
    chk("binchg_done", 32'(done), 32'd1);
    chk_result("binchg", 19);
    tick();

    // reset on 3rd SHIFT edge aborts conversion
    bin = 5'd25;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk_result("abort", 0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_done += int'(done) + int'(busy);
    end
    chk("abort_quiet", 32'(n_done), 32'd0);
    chk_result("abort_hold", 0);
    conv("b25", 5'd25);

    for (int i = 0; i < 20; i++) begin
      conv("rand", 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
